// File: rtl/alu_pkg.sv
// Purpose: shared constants for the execute-stage ALU (op codes, operand-B selects).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int XLEN = 32;

    // ALUCtl encodings: {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    // ALUBSrc encodings
    localparam logic [1:0] BSRC_RD2  = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;
    localparam logic [1:0] BSRC_ZERO = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational op/compare unit; computes result, zero and less flags from A, B, op.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b (operands), ctl (op code) in; result, zero (result==0), less (A<B) out.
module alu_core
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            less
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    // Only the low five bits of B steer shifts; B[31:5] is ignored.
    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result = '0;
        unique case (ctl)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);
    // Branch unit reads this for every op: unsigned only for the SLTU encoding.
    assign less = (ctl == ALU_SLTU) ? lt_unsigned : lt_signed;

endmodule

// File: rtl/alu.sv
// Purpose: execute-stage ALU; operand muxes, alu_core, and EX/MEM output registers.
// Latency: 1 cycle (result/flags captured on every rising clk edge).
// Backpressure: none; no enable or handshake, a new op is accepted every cycle.
// Ports: clk, rst_n (async active-low); ALUASrc/ALUBSrc operand selects, ALUCtl op code;
//        ReadData1, ReadData2, pc, ImmGenOut data in; ALUResult, Zero, Less registered out.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ALUASrc,
    input  logic [1:0]      ALUBSrc,
    input  logic [3:0]      ALUCtl,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] ImmGenOut,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Less
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] next_result;
    logic            next_zero;
    logic            next_less;

    assign op_a = ALUASrc ? pc : ReadData1;

    always_comb begin
        op_b = '0;
        unique case (ALUBSrc)
            BSRC_RD2:  op_b = ReadData2;
            BSRC_IMM:  op_b = ImmGenOut;
            BSRC_FOUR: op_b = XLEN'(4);
            BSRC_ZERO: op_b = '0;
            default:   op_b = '0;
        endcase
    end

    alu_core u_core (
        .a      (op_a),
        .b      (op_b),
        .ctl    (ALUCtl),
        .result (next_result),
        .zero   (next_zero),
        .less   (next_less)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
            Zero      <= 1'b0;
            Less      <= 1'b0;
        end else begin
            ALUResult <= next_result;
            Zero      <= next_zero;
            Less      <= next_less;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Purpose: directed self-checking bench for alu; one task per feature, inline comparisons.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: n/a.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ALUASrc;
    logic [1:0]  ALUBSrc;
    logic [3:0]  ALUCtl;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] pc;
    logic [31:0] ImmGenOut;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Less;

    int checks;
    int failures;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUASrc   (ALUASrc),
        .ALUBSrc   (ALUBSrc),
        .ALUCtl    (ALUCtl),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .pc        (pc),
        .ImmGenOut (ImmGenOut),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Less      (Less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic asrc, input logic [1:0] bsrc, input logic [3:0] ctl,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] pcv, input logic [31:0] imm);
        @(negedge clk);
        ALUASrc   = asrc;
        ALUBSrc   = bsrc;
        ALUCtl    = ctl;
        ReadData1 = rd1;
        ReadData2 = rd2;
        pc        = pcv;
        ImmGenOut = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b0 || Less !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got res=%h z=%b l=%b want res=0 z=0 l=0", ALUResult, Zero, Less);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        apply(1'b0, BSRC_RD2, ALU_ADD, 32'd10, 32'd20, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd30 || Zero !== 1'b0 || Less !== 1'b1) begin
            failures++;
            $display("FAIL add: got res=%0d z=%b l=%b want res=30 z=0 l=1", ALUResult, Zero, Less);
        end
        apply(1'b0, BSRC_RD2, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1 || Less !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap: got res=%h z=%b l=%b want res=0 z=1 l=1", ALUResult, Zero, Less);
        end
        apply(1'b0, BSRC_ZERO, ALU_ADD, 32'd7, 32'd99, 32'd0, 32'd55);
        checks++;
        if (ALUResult !== 32'd7 || Less !== 1'b0) begin
            failures++;
            $display("FAIL add_bzero: got res=%0d l=%b want res=7 l=0", ALUResult, Less);
        end
    endtask

    task automatic test_sub;
        apply(1'b0, BSRC_RD2, ALU_SUB, 32'd100, 32'd50, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd50 || Zero !== 1'b0 || Less !== 1'b0) begin
            failures++;
            $display("FAIL sub: got res=%0d z=%b l=%b want res=50 z=0 l=0", ALUResult, Zero, Less);
        end
        apply(1'b0, BSRC_RD2, ALU_SUB, 32'd5, 32'd5, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero: got res=%0d z=%b want res=0 z=1", ALUResult, Zero);
        end
    endtask

    task automatic test_shift;
        apply(1'b1, BSRC_IMM, ALU_SLL, 32'd0, 32'd0, 32'd10, 32'd4);
        checks++;
        if (ALUResult !== 32'd160) begin
            failures++;
            $display("FAIL sll: got %0d want 160", ALUResult);
        end
        apply(1'b0, BSRC_IMM, ALU_SRL, 32'd32, 32'd0, 32'd0, 32'd2);
        checks++;
        if (ALUResult !== 32'd8) begin
            failures++;
            $display("FAIL srl: got %0d want 8", ALUResult);
        end
        apply(1'b0, BSRC_IMM, ALU_SRA, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd2);
        checks++;
        if (ALUResult !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sra: got %h want ffffffff", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_SLL, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'h0000_1234) begin
            failures++;
            $display("FAIL shift_zero: got %h want 00001234", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_SRL, 32'h8000_0000, 32'h0000_0021, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'h4000_0000) begin
            failures++;
            $display("FAIL shift_upper_ignored: got %h want 40000000", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra_neg: got %h want f8000000", ALUResult);
        end
    endtask

    task automatic test_compare;
        apply(1'b0, BSRC_RD2, ALU_SLT, 32'd10, 32'd20, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd1 || Less !== 1'b1) begin
            failures++;
            $display("FAIL slt: got res=%0d l=%b want res=1 l=1", ALUResult, Less);
        end
        apply(1'b0, BSRC_RD2, ALU_SLT, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd1 || Less !== 1'b1 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL slt_neg: got res=%0d z=%b l=%b want res=1 z=0 l=1", ALUResult, Zero, Less);
        end
        apply(1'b0, BSRC_RD2, ALU_SLTU, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd0 || Less !== 1'b0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL sltu_big: got res=%0d z=%b l=%b want res=0 z=1 l=0", ALUResult, Zero, Less);
        end
        apply(1'b0, BSRC_RD2, ALU_SLTU, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd1 || Less !== 1'b1) begin
            failures++;
            $display("FAIL sltu_small: got res=%0d l=%b want res=1 l=1", ALUResult, Less);
        end
    endtask

    task automatic test_logic;
        apply(1'b1, BSRC_FOUR, ALU_XOR, 32'd0, 32'd0, 32'd0, 32'd5);
        checks++;
        if (ALUResult !== 32'd4) begin
            failures++;
            $display("FAIL xor_const4: got %0d want 4", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_OR, 32'd32, 32'd0, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd32) begin
            failures++;
            $display("FAIL or: got %0d want 32", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_AND, 32'd32, 32'd32, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd32) begin
            failures++;
            $display("FAIL and: got %0d want 32", ALUResult);
        end
        apply(1'b0, BSRC_RD2, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'h00F0_00F0) begin
            failures++;
            $display("FAIL and_mask: got %h want 00f000f0", ALUResult);
        end
    endtask

    task automatic test_passb_and_illegal;
        apply(1'b0, BSRC_IMM, ALU_PASSB, 32'd0, 32'd0, 32'd0, 32'hABCD_E000);
        checks++;
        if (ALUResult !== 32'hABCD_E000 || Less !== 1'b0) begin
            failures++;
            $display("FAIL passb: got res=%h l=%b want res=abcde000 l=0", ALUResult, Less);
        end
        apply(1'b0, BSRC_RD2, 4'b1111, 32'd9, 32'd3, 32'd0, 32'd0);
        checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op: got res=%h z=%b want res=0 z=1", ALUResult, Zero);
        end
    endtask

    task automatic test_async_reset;
        apply(1'b0, BSRC_RD2, ALU_ADD, 32'd10, 32'd20, 32'd0, 32'd0);
        // Assert reset away from any edge: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ALUResult !== 32'd0 || Zero !== 1'b0 || Less !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got res=%0d z=%b l=%b want all 0", ALUResult, Zero, Less);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ALUResult !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold: got res=%0d want 0 before first edge", ALUResult);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALUResult !== 32'd30 || Less !== 1'b1) begin
            failures++;
            $display("FAIL after_release: got res=%0d l=%b want res=30 l=1", ALUResult, Less);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        ALUASrc   = 1'b0;
        ALUBSrc   = 2'b00;
        ALUCtl    = 4'b0000;
        ReadData1 = 32'd0;
        ReadData2 = 32'd0;
        pc        = 32'd0;
        ImmGenOut = 32'd0;

        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_compare();
        test_logic();
        test_passb_and_illegal();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
